// File: rtl/cnt_job_scheduler.sv
// cnt_job_scheduler: round-robin scheduler sharing one loadable up-counter between requesters A and B
// Ports:
//   clk, rst_n (sync, active-low), ena (global freeze when low)
//   req_a/req_b, start_a/start_b, len_a/len_b : job requests, sampled at grant
//   gnt_a/gnt_b, busy                         : grant (LOAD..DONE) and non-idle status
//   done, done_id, result, aborted            : registered completion report
//   cnt_load, cnt_dat, cnt_en, cnt_val        : counter datapath control and readback
// Optional feature: define CNT_SCHED_ABORT_EN to end a job early when its requester drops req in RUN.
module cnt_job_scheduler #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] start_a,
    input  logic [WIDTH-1:0] start_b,
    input  logic [LEN_W-1:0] len_a,
    input  logic [LEN_W-1:0] len_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] result,
    output logic             aborted,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_dat,
    output logic             cnt_en,
    input  logic [WIDTH-1:0] cnt_val
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic id_q, id_d;
    logic ptr_q, ptr_d;
    logic done_q, done_d;
    logic done_id_q, done_id_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic pick;
`ifdef CNT_SCHED_ABORT_EN
    logic abt_q, abt_d;
    logic aborted_q, aborted_d;
    assign aborted = aborted_q;
`else
    assign aborted = 1'b0;
`endif
    assign busy     = state_q != IDLE;
    assign gnt_a    = busy & ~id_q;
    assign gnt_b    = busy & id_q;
    assign cnt_load = ena & (state_q == LOAD);
    assign cnt_en   = ena & ((state_q == LOAD) | (state_q == RUN));
    assign cnt_dat  = start_q;
    assign done     = done_q;
    assign done_id  = done_id_q;
    assign result   = result_q;
    always_comb begin
        // ptr_q=1 prefers B; a lone requester always wins
        pick      = ptr_q ? req_b : ~req_a;
        state_d   = state_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        start_d   = start_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        result_d  = result_q;
`ifdef CNT_SCHED_ABORT_EN
        abt_d     = abt_q;
        aborted_d = aborted_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    state_d = LOAD;
                    id_d    = pick;
                    ptr_d   = ~pick;
                    start_d = pick ? start_b : start_a;
                    rem_d   = pick ? len_b : len_a;
`ifdef CNT_SCHED_ABORT_EN
                    abt_d     = 1'b0;
                    aborted_d = 1'b0;
`endif
                end
            end
            LOAD: state_d = (rem_q == '0) ? DONE : RUN;
            RUN: begin
                rem_d   = rem_q - LEN_W'(1);
                state_d = (rem_q == LEN_W'(1)) ? DONE : RUN;
`ifdef CNT_SCHED_ABORT_EN
                if (!(id_q ? req_b : req_a)) begin
                    state_d = DONE;
                    abt_d   = 1'b1;
                end
`endif
            end
            default: begin
                state_d   = IDLE;
                done_d    = 1'b1;
                done_id_d = id_q;
                result_d  = cnt_val;
`ifdef CNT_SCHED_ABORT_EN
                aborted_d = abt_q;
`endif
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            id_q      <= 1'b0;
            ptr_q     <= 1'b0;
            start_q   <= '0;
            rem_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            result_q  <= '0;
`ifdef CNT_SCHED_ABORT_EN
            abt_q     <= 1'b0;
            aborted_q <= 1'b0;
`endif
        end else if (ena) begin
            state_q   <= state_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
            start_q   <= start_d;
            rem_q     <= rem_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            result_q  <= result_d;
`ifdef CNT_SCHED_ABORT_EN
            abt_q     <= abt_d;
            aborted_q <= aborted_d;
`endif
        end
    end
endmodule

// File: tb/tb_cnt_job_scheduler.sv
// tb_cnt_job_scheduler: self-checking bench with a job-level reference model and an attached counter
module tb_cnt_job_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b1;
    logic req_a = 1'b0, req_b = 1'b0;
    logic [7:0] start_a = '0, start_b = '0, len_a = '0, len_b = '0;
    logic gnt_a, gnt_b, busy, done, done_id, aborted, cnt_load, cnt_en;
    logic [7:0] result, cnt_dat;
    logic [7:0] cnt_val = '0;
    int checks = 0;
    int errors = 0;

    cnt_job_scheduler #(.WIDTH(8), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .req_a(req_a), .req_b(req_b),
        .start_a(start_a), .start_b(start_b),
        .len_a(len_a), .len_b(len_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .busy(busy),
        .done(done), .done_id(done_id), .result(result), .aborted(aborted),
        .cnt_load(cnt_load), .cnt_dat(cnt_dat), .cnt_en(cnt_en), .cnt_val(cnt_val)
    );

    always #5 clk = ~clk;

    // the loadable up-counter the scheduler drives
    always @(posedge clk) begin
        if (!rst_n) cnt_val <= '0;
        else if (cnt_load) cnt_val <= cnt_dat;
        else if (cnt_en) cnt_val <= cnt_val + 8'd1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        ena = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task test_reset;
        req_a = 1'b1;
        req_b = 1'b1;
        start_a = 8'h5A;
        len_a = 8'd3;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({gnt_a, gnt_b, busy, done, done_id, aborted, cnt_load, cnt_en} !== 8'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 00000000", {gnt_a, gnt_b, busy, done, done_id, aborted, cnt_load, cnt_en});
        end
        checks++;
        if ({result, cnt_dat} !== 16'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0000", {result, cnt_dat});
        end
        req_a = 1'b0;
        req_b = 1'b0;
        rst_n = 1'b1;
    endtask

    task test_single;
        logic [5:0] exp_v;
        do_reset();
        req_a = 1'b1;
        start_a = 8'h10;
        len_a = 8'd5;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            exp_v = {c <= 7, 1'b0, c <= 7, c == 1, c <= 6, c == 8};
            checks++;
            if ({gnt_a, gnt_b, busy, cnt_load, cnt_en, done} !== exp_v) begin
                errors++;
                $display("FAIL single_ctrl c=%0d got %b exp %b", c, {gnt_a, gnt_b, busy, cnt_load, cnt_en, done}, exp_v);
            end
            if (c == 2) begin
                checks++;
                if (cnt_dat !== 8'h10) begin
                    errors++;
                    $display("FAIL single_dat got %h exp 10", cnt_dat);
                end
            end
            if (c == 8) begin
                checks++;
                if ({done_id, result} !== {1'b0, 8'h15}) begin
                    errors++;
                    $display("FAIL single_result got id=%b res=%h exp id=0 res=15", done_id, result);
                end
                req_a = 1'b0;
            end
        end
    endtask

    task test_round_robin;
        logic [7:0] sa, sb;
        logic [2:0] exp_v;
        int k, ph;
        do_reset();
        sa = 8'($urandom);
        sb = 8'($urandom);
        start_a = sa;
        start_b = sb;
        len_a = 8'd2;
        len_b = 8'd2;
        req_a = 1'b1;
        req_b = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            k = (c - 1) / 5;
            ph = (c - 1) % 5;
            exp_v = {ph <= 3 && k % 2 == 0, ph <= 3 && k % 2 == 1, ph == 4};
            checks++;
            if ({gnt_a, gnt_b, done} !== exp_v) begin
                errors++;
                $display("FAIL rr_ctrl c=%0d got %b exp %b", c, {gnt_a, gnt_b, done}, exp_v);
            end
            if (ph == 4) begin
                checks++;
                if ({done_id, result} !== {k % 2 == 1, (k % 2 == 1 ? sb : sa) + 8'd2}) begin
                    errors++;
                    $display("FAIL rr_result c=%0d got id=%b res=%h exp id=%0d res=%h", c, done_id, result, k % 2, (k % 2 == 1 ? sb : sa) + 8'd2);
                end
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    task test_wrap;
        logic [2:0] exp_v;
        logic [3:0] exp_z;
        do_reset();
        req_b = 1'b1;
        start_b = 8'hFE;
        len_b = 8'd4;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            exp_v = {1'b0, c <= 6, c == 7};
            checks++;
            if ({gnt_a, gnt_b, done} !== exp_v) begin
                errors++;
                $display("FAIL wrap_ctrl c=%0d got %b exp %b", c, {gnt_a, gnt_b, done}, exp_v);
            end
            if (c == 7) begin
                checks++;
                if ({done_id, result} !== {1'b1, 8'h02}) begin
                    errors++;
                    $display("FAIL wrap_result got id=%b res=%h exp id=1 res=02", done_id, result);
                end
                req_b = 1'b0;
            end
        end
        req_a = 1'b1;
        start_a = 8'h33;
        len_a = 8'd0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            exp_z = {c <= 2, c == 1, c == 1, c == 3};
            checks++;
            if ({gnt_a, cnt_load, cnt_en, done} !== exp_z) begin
                errors++;
                $display("FAIL len0_ctrl c=%0d got %b exp %b", c, {gnt_a, cnt_load, cnt_en, done}, exp_z);
            end
            if (c == 3) begin
                checks++;
                if ({done_id, result} !== {1'b0, 8'h33}) begin
                    errors++;
                    $display("FAIL len0_result got id=%b res=%h exp id=0 res=33", done_id, result);
                end
                req_a = 1'b0;
            end
        end
    endtask

    task test_stall;
        logic [7:0] s;
        logic [2:0] exp_v;
        do_reset();
        s = 8'($urandom);
        req_a = 1'b1;
        start_a = s;
        len_a = 8'd6;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            exp_v = {c <= 2 || (c >= 6 && c <= 10), c <= 11, c == 12};
            checks++;
            if ({cnt_en, busy, done} !== exp_v) begin
                errors++;
                $display("FAIL stall_ctrl c=%0d got %b exp %b", c, {cnt_en, busy, done}, exp_v);
            end
            if (c == 12) begin
                checks++;
                if (result !== s + 8'd6) begin
                    errors++;
                    $display("FAIL stall_result got %h exp %h", result, s + 8'd6);
                end
                req_a = 1'b0;
            end
            if (c == 2) ena = 1'b0;
            if (c == 5) ena = 1'b1;
        end
    endtask

    task test_reset_midrun;
        do_reset();
        req_a = 1'b1;
        start_a = 8'h40;
        len_a = 8'd10;
        repeat (4) @(negedge clk);
        checks++;
        if ({busy, gnt_a} !== 2'b11) begin
            errors++;
            $display("FAIL midrun_busy got %b exp 11", {busy, gnt_a});
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt_a, gnt_b, busy, done, done_id, aborted, cnt_load, cnt_en} !== 8'b0) begin
            errors++;
            $display("FAIL midrun_reset_ctrl got %b exp 00000000", {gnt_a, gnt_b, busy, done, done_id, aborted, cnt_load, cnt_en});
        end
        checks++;
        if ({result, cnt_dat} !== 16'h0) begin
            errors++;
            $display("FAIL midrun_reset_data got %h exp 0000", {result, cnt_dat});
        end
        rst_n = 1'b1;
        req_a = 1'b1;
        req_b = 1'b1;
        len_a = 8'd1;
        len_b = 8'd1;
        @(negedge clk);
        checks++;
        if ({gnt_a, gnt_b} !== 2'b10) begin
            errors++;
            $display("FAIL midrun_regrant got %b exp 10", {gnt_a, gnt_b});
        end
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task test_abort;
        int exp_dc;
        logic [7:0] exp_r;
        logic exp_ab;
`ifdef CNT_SCHED_ABORT_EN
        exp_dc = 6;
        exp_r = 8'h03;
        exp_ab = 1'b1;
`else
        exp_dc = 13;
        exp_r = 8'h0A;
        exp_ab = 1'b0;
`endif
        do_reset();
        req_a = 1'b1;
        start_a = 8'h00;
        len_a = 8'd10;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            checks++;
            if (done !== (c == exp_dc)) begin
                errors++;
                $display("FAIL abort_done c=%0d got %b exp %b", c, done, c == exp_dc);
            end
            if (c == exp_dc) begin
                checks++;
                if ({result, aborted} !== {exp_r, exp_ab}) begin
                    errors++;
                    $display("FAIL abort_result got res=%h ab=%b exp res=%h ab=%b", result, aborted, exp_r, exp_ab);
                end
            end
            if (c == 4) req_a = 1'b0;
        end
        req_a = 1'b1;
        len_a = 8'd1;
        @(negedge clk);
        checks++;
        if ({gnt_a, aborted} !== 2'b10) begin
            errors++;
            $display("FAIL abort_clear got %b exp 10", {gnt_a, aborted});
        end
        req_a = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // job-level model: round-robin pick, done at decision+3+len, result=(start+len) mod 256
    task test_random;
        bit busy_m, cur, pref_b;
        int load_c, done_c, l;
        logic [7:0] exp_res;
        logic [2:0] exp_v;
        do_reset();
        busy_m = 1'b0;
        cur = 1'b0;
        pref_b = 1'b0;
        load_c = 0;
        done_c = 0;
        exp_res = '0;
        for (int c = 0; c < 600; c++) begin
            exp_v = {busy_m && !cur && c >= load_c && c < done_c,
                     busy_m && cur && c >= load_c && c < done_c,
                     busy_m && c == done_c};
            checks++;
            if ({gnt_a, gnt_b, done} !== exp_v) begin
                errors++;
                $display("FAIL rand_ctrl c=%0d got %b exp %b", c, {gnt_a, gnt_b, done}, exp_v);
            end
            if (busy_m && c == done_c) begin
                checks++;
                if ({done_id, result} !== {cur, exp_res}) begin
                    errors++;
                    $display("FAIL rand_result c=%0d got id=%b res=%h exp id=%b res=%h", c, done_id, result, cur, exp_res);
                end
                busy_m = 1'b0;
                if ($urandom_range(0, 1) == 1) begin
                    if (cur) begin
                        start_b = 8'($urandom);
                        len_b = 8'($urandom_range(0, 9));
                    end else begin
                        start_a = 8'($urandom);
                        len_a = 8'($urandom_range(0, 9));
                    end
                end else if (cur) req_b = 1'b0;
                else req_a = 1'b0;
            end
            if (!req_a && $urandom_range(0, 3) == 0) begin
                req_a = 1'b1;
                start_a = 8'($urandom);
                len_a = 8'($urandom_range(0, 9));
            end
            if (!req_b && $urandom_range(0, 3) == 0) begin
                req_b = 1'b1;
                start_b = 8'($urandom);
                len_b = 8'($urandom_range(0, 9));
            end
            if (!busy_m && (req_a || req_b)) begin
                cur = (req_a && req_b) ? pref_b : req_b;
                pref_b = !cur;
                l = cur ? int'(len_b) : int'(len_a);
                load_c = c + 1;
                done_c = c + 3 + l;
                exp_res = (cur ? start_b : start_a) + (cur ? len_b : len_a);
                busy_m = 1'b1;
            end
            @(negedge clk);
        end
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (15) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_stall();
        test_reset_midrun();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
